alu_serial: RTL

ALU_SERIAL -- requirements
Module: alu_serial

---
 rtl/alu_serial_pkg.sv | 55 +++++
 rtl/alu_serial_if.sv | 25 ++
 rtl/alu_slice.sv | 48 ++++
 rtl/alu_serial.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// Shared types for the bit-serial (slice-serial) ALU: opcodes, flag bit
// positions, controller states and the per-slice operating mode.
package alu_serial_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_ADC    = 4'd1,
        OP_SUB    = 4'd2,
        OP_SBC    = 4'd3,
        OP_AND    = 4'd4,
        OP_XOR    = 4'd5,
        OP_OR     = 4'd6,
        OP_CP     = 4'd7,
        OP_INC    = 4'd8,
        OP_DEC    = 4'd9,
        OP_COPY_A = 4'd10,
        OP_COPY_B = 4'd11
    } AluOp;

    localparam int FLAG_C = 0;
    localparam int FLAG_H = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } FsmState;

    typedef enum logic [2:0] {
        SL_ADD    = 3'd0,
        SL_SUB    = 3'd1,
        SL_AND    = 3'd2,
        SL_XOR    = 3'd3,
        SL_OR     = 3'd4,
        SL_PASS_A = 3'd5,
        SL_PASS_B = 3'd6
    } SliceMode;

    // Map an opcode onto the slice datapath; INC/DEC use the adder with b=1,
    // CP uses the subtractor for its flags, unknown opcodes pass a through.
    function automatic SliceMode sliceMode(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADC, OP_INC:         sliceMode = SL_ADD;
            OP_SUB, OP_SBC, OP_CP, OP_DEC:  sliceMode = SL_SUB;
            OP_AND:                         sliceMode = SL_AND;
            OP_XOR:                         sliceMode = SL_XOR;
            OP_OR:                          sliceMode = SL_OR;
            OP_COPY_B:                      sliceMode = SL_PASS_B;
            default:                        sliceMode = SL_PASS_A;
        endcase
    endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Request/response bundle of the serial ALU; the slave side is the ALU.
interface alu_serial_if #(
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        flag_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] result;
    logic [3:0]        flag_out;

    modport master (
        output req_valid, op, a, b, flag_in, rsp_ready,
        input  req_ready, rsp_valid, result, flag_out
    );

    modport slave (
        input  req_valid, op, a, b, flag_in, rsp_ready,
        output req_ready, rsp_valid, result, flag_out
    );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit ALU slice. carry_i/carry_o carry a borrow when
// subtracting; hcarry_o is the carry/borrow out of local bit HBIT.
module alu_slice
    import alu_serial_pkg::*;
#(
    parameter int SLICE_W = 8,
    parameter int HBIT    = 3
) (
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  SliceMode           mode_i,
    input  logic               carry_i,
    output logic [SLICE_W-1:0] y_o,
    output logic               carry_o,
    output logic               hcarry_o,
    output logic               zero_o
);

    logic [SLICE_W-1:0] bx;
    logic [SLICE_W-1:0] sum;
    logic [SLICE_W:0]   chain;
    logic               isSub;

    // Ripple adder; subtraction is a + ~b + ~borrow with the carries inverted back to borrows.
    always_comb begin
        isSub    = (mode_i == SL_SUB);
        bx       = isSub ? ~b_i : b_i;
        sum      = '0;
        chain    = '0;
        chain[0] = isSub ? ~carry_i : carry_i;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]       = a_i[i] ^ bx[i] ^ chain[i];
            chain[i + 1] = (a_i[i] & bx[i]) | (a_i[i] & chain[i]) | (bx[i] & chain[i]);
        end
        carry_o  = isSub ? ~chain[SLICE_W]  : chain[SLICE_W];
        hcarry_o = isSub ? ~chain[HBIT + 1] : chain[HBIT + 1];
        case (mode_i)
            SL_ADD, SL_SUB: y_o = sum;
            SL_AND:         y_o = a_i & b_i;
            SL_XOR:         y_o = a_i ^ b_i;
            SL_OR:          y_o = a_i | b_i;
            SL_PASS_B:      y_o = b_i;
            default:        y_o = a_i;
        endcase
        zero_o = (y_o == '0);
    end

endmodule

// File: rtl/alu_serial.sv
// Slice-serial ALU: one SLICE_W slice per cycle, LSB first, with the carry,
// half-carry and zero flag carried between slices in registers.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_serial_if.slave  bus
);

    localparam int NSLICE  = DATA_W / SLICE_W;
    localparam int IDX_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int HPOS    = (DATA_W >= 5) ? DATA_W - 5 : 0;
    localparam int H_SLICE = HPOS / SLICE_W;
    localparam int HBIT    = HPOS % SLICE_W;

    FsmState           stateQ, stateD;
    logic [IDX_W-1:0]  idxQ, idxD;
    logic              carryQ, carryD;
    logic [3:0]        opQ, opD;
    logic [DATA_W-1:0] aQ, aD;
    logic [DATA_W-1:0] bQ, bD;
    logic [3:0]        flagInQ, flagInD;
    logic [DATA_W-1:0] resultQ, resultD;
    logic              zeroQ, zeroD;
    logic              hQ, hD;
    logic [3:0]        flagOutQ, flagOutD;

    logic [SLICE_W-1:0] sliceY;
    logic [SLICE_W-1:0] resultSlice;
    logic               sliceCarry;
    logic               sliceH;
    logic               sliceZero;
    logic               lastSlice;
    logic               finalZero;
    logic               finalH;
    logic [3:0]         finalFlags;

    // The operand registers shift right each cycle, so the slice always sees their low bits.
    alu_slice #(
        .SLICE_W (SLICE_W),
        .HBIT    (HBIT)
    ) u_slice (
        .a_i      (aQ[SLICE_W-1:0]),
        .b_i      (bQ[SLICE_W-1:0]),
        .mode_i   (sliceMode(opQ)),
        .carry_i  (carryQ),
        .y_o      (sliceY),
        .carry_o  (sliceCarry),
        .hcarry_o (sliceH),
        .zero_o   (sliceZero)
    );

    assign lastSlice     = (idxQ == IDX_W'(NSLICE - 1));
    assign resultSlice   = (opQ == OP_CP) ? aQ[SLICE_W-1:0] : sliceY;
    assign bus.req_ready = (stateQ == ST_IDLE);
    assign bus.rsp_valid = (stateQ == ST_DONE);
    assign bus.result    = resultQ;
    assign bus.flag_out  = flagOutQ;

    // Controller next state: accept in IDLE, run NSLICE slices, wait for the consumer.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_IDLE: if (bus.req_valid) stateD = ST_BUSY;
            ST_BUSY: if (lastSlice)     stateD = ST_DONE;
            ST_DONE: if (bus.rsp_ready) stateD = ST_IDLE;
            default:                    stateD = ST_IDLE;
        endcase
    end

    // Final flags, using this cycle's top-slice carry and the accumulated Z/H.
    always_comb begin
        finalZero  = zeroQ & sliceZero;
        finalH     = (idxQ == IDX_W'(H_SLICE)) ? sliceH : hQ;
        finalFlags = flagInQ;
        case (opQ)
            OP_ADD, OP_ADC, OP_INC, OP_SUB, OP_SBC, OP_CP, OP_DEC: begin
                finalFlags[FLAG_C] = sliceCarry;
                finalFlags[FLAG_H] = finalH;
                finalFlags[FLAG_N] = 1'b0;
                finalFlags[FLAG_Z] = finalZero;
                if (opQ == OP_SUB || opQ == OP_SBC || opQ == OP_CP || opQ == OP_DEC) begin
                    finalFlags[FLAG_N] = 1'b1;
                end
                if (opQ == OP_INC || opQ == OP_DEC) begin
                    finalFlags[FLAG_C] = flagInQ[FLAG_C];
                end
            end
            OP_AND, OP_XOR, OP_OR: begin
                finalFlags[FLAG_C] = 1'b0;
                finalFlags[FLAG_H] = (opQ == OP_AND);
                finalFlags[FLAG_N] = 1'b0;
                finalFlags[FLAG_Z] = finalZero;
            end
            default: finalFlags = flagInQ;
        endcase
    end

    // Datapath next state: capture on accept, then shift one slice per BUSY cycle.
    always_comb begin
        idxD     = idxQ;
        carryD   = carryQ;
        opD      = opQ;
        aD       = aQ;
        bD       = bQ;
        flagInD  = flagInQ;
        resultD  = resultQ;
        zeroD    = zeroQ;
        hD       = hQ;
        flagOutD = flagOutQ;
        case (stateQ)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    opD     = bus.op;
                    aD      = bus.a;
                    bD      = (bus.op == OP_INC || bus.op == OP_DEC) ? DATA_W'(1) : bus.b;
                    flagInD = bus.flag_in;
                    carryD  = (bus.op == OP_ADC || bus.op == OP_SBC) ? bus.flag_in[FLAG_C] : 1'b0;
                    idxD    = '0;
                    zeroD   = 1'b1;
                    hD      = 1'b0;
                end
            end
            ST_BUSY: begin
                resultD = DATA_W'({resultSlice, resultQ} >> SLICE_W);
                aD      = aQ >> SLICE_W;
                bD      = bQ >> SLICE_W;
                carryD  = sliceCarry;
                zeroD   = finalZero;
                hD      = finalH;
                idxD    = idxQ + 1'b1;
                if (lastSlice) begin
                    flagOutD = finalFlags;
                    idxD     = '0;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ   <= ST_IDLE;
            idxQ     <= '0;
            carryQ   <= 1'b0;
            opQ      <= '0;
            aQ       <= '0;
            bQ       <= '0;
            flagInQ  <= '0;
            resultQ  <= '0;
            zeroQ    <= 1'b0;
            hQ       <= 1'b0;
            flagOutQ <= '0;
        end else begin
            stateQ   <= stateD;
            idxQ     <= idxD;
            carryQ   <= carryD;
            opQ      <= opD;
            aQ       <= aD;
            bQ       <= bD;
            flagInQ  <= flagInD;
            resultQ  <= resultD;
            zeroQ    <= zeroD;
            hQ       <= hD;
            flagOutQ <= flagOutD;
        end
    end

endmodule
